// File: rtl/decodificare_secv.sv
// Iterative IDEA decryption core.
// Each block needs NR+1 passes. A pass is 16 cycles of inverse computation and then one
// cycle that applies the round, or the output transform on the last pass.
// Decryption subkeys are derived on the fly from the latched user key.
module decodificare_secv #(
  parameter int unsigned NR = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] K,
  input  logic [63:0]  Y,
  output logic         ready,
  output logic         done,
  output logic [63:0]  X_OUT
);

  localparam int unsigned NumKeys  = 6 * NR + 4;
  localparam logic [3:0]  LastPass = 4'(NR + 1);

  typedef enum logic [1:0] {StIdle, StInv, StRnd} state_e;

  // Multiplication modulo 2^16+1; the all-zero word stands for 2^16.
  function automatic logic [15:0] inmultire(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] lo, hi, res;
    p = 32'h0;
    if (a == 16'h0) begin
      res = 16'h1 - b;
    end else if (b == 16'h0) begin
      res = 16'h1 - a;
    end else begin
      p   = {16'h0, a} * {16'h0, b};
      lo  = p[15:0];
      hi  = p[31:16];
      // 2^16 == -1 mod 2^16+1, so p == lo - hi; a borrow wraps by +2^16+1.
      res = lo - hi + {15'h0, (lo < hi)};
    end
    return res;
  endfunction

  // One IDEA round, middle words swapped on output.
  function automatic logic [63:0] idea_round(input logic [63:0] x,
                                             input logic [15:0] k1, input logic [15:0] k2,
                                             input logic [15:0] k3, input logic [15:0] k4,
                                             input logic [15:0] k5, input logic [15:0] k6);
    logic [15:0] a, b, c, d, e, f, g, h, i, j;
    a = inmultire(x[63:48], k1);
    b = x[47:32] + k2;
    c = x[31:16] + k3;
    d = inmultire(x[15:0], k4);
    e = a ^ c;
    f = b ^ d;
    g = inmultire(e, k5);
    h = f + g;
    i = inmultire(h, k6);
    j = g + i;
    return {a ^ i, c ^ i, b ^ j, d ^ j};
  endfunction

  // Encryption subkey j (1-based): 16-bit slice (j-1)%8 of the key rotated by 25*((j-1)/8).
  function automatic logic [15:0] key_slice(input logic [127:0] kr, input int unsigned j);
    logic [255:0] dbl;
    int unsigned  amt;
    int unsigned  s;
    amt = (25 * ((j - 1) / 8)) % 128;
    s   = (j - 1) % 8;
    dbl = {kr, kr} << amt;
    return dbl[8'(255 - 16 * s) -: 16];
  endfunction

  state_e        state_q;
  logic [127:0]  kr_q;
  logic [63:0]   d_q;
  logic [63:0]   x_out_q;
  logic [3:0]    r_q;
  logic [3:0]    cnt_q;
  logic [15:0]   acc1_q, acc4_q;
  logic          done_q;

  logic [15:0]   z_tab [64];
  logic [5:0]    pass_cnt, b_idx;
  logic [15:0]   z_bm1, z_b0, z_b1, z_b2, z_b3, z_b4;
  logic          outer_pass;
  logic [15:0]   dk2, dk3;
  logic [15:0]   acc1_d, acc4_d;
  logic [63:0]   round_out, final_out;

  // Subkey table: fixed rotations of the latched key, entries outside 1..NumKeys read zero.
  always_comb begin
    for (int unsigned j = 0; j < 64; j++) begin
      z_tab[6'(j)] = (j >= 1 && j <= NumKeys) ? key_slice(kr_q, j) : 16'h0;
    end
  end

  // Decryption subkeys, inverse-engine next values and datapath results for the current pass.
  always_comb begin
    pass_cnt   = {2'b00, LastPass} - {2'b00, r_q};
    b_idx      = pass_cnt * 6'd6;
    z_bm1      = z_tab[b_idx - 6'd1];
    z_b0       = z_tab[b_idx];
    z_b1       = z_tab[b_idx + 6'd1];
    z_b2       = z_tab[b_idx + 6'd2];
    z_b3       = z_tab[b_idx + 6'd3];
    z_b4       = z_tab[b_idx + 6'd4];
    outer_pass = (r_q == 4'd1) || (r_q == LastPass);
    dk2        = outer_pass ? (16'h0 - z_b2) : (16'h0 - z_b3);
    dk3        = outer_pass ? (16'h0 - z_b3) : (16'h0 - z_b2);
    // Square-and-multiply over 16 steps yields a^(2^16-1), the inverse of a.
    acc1_d     = inmultire(inmultire(acc1_q, acc1_q), z_b1);
    acc4_d     = inmultire(inmultire(acc4_q, acc4_q), z_b4);
    round_out  = idea_round(d_q, acc1_q, dk2, dk3, acc4_q, z_bm1, z_b0);
    // Output transform also undoes the round's middle-word swap.
    final_out  = {inmultire(d_q[63:48], acc1_q), d_q[31:16] + dk2,
                  d_q[47:32] + dk3, inmultire(d_q[15:0], acc4_q)};
  end

  // Control FSM and all datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      kr_q    <= '0;
      d_q     <= '0;
      x_out_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      acc1_q  <= '0;
      acc4_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            kr_q    <= K;
            d_q     <= Y;
            r_q     <= 4'd1;
            cnt_q   <= 4'd0;
            acc1_q  <= 16'd1;
            acc4_q  <= 16'd1;
            state_q <= StInv;
          end
        end
        StInv: begin
          acc1_q <= acc1_d;
          acc4_q <= acc4_d;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= StRnd;
          end
        end
        StRnd: begin
          if (r_q != LastPass) begin
            d_q     <= round_out;
            r_q     <= r_q + 4'd1;
            cnt_q   <= 4'd0;
            acc1_q  <= 16'd1;
            acc4_q  <= 16'd1;
            state_q <= StInv;
          end else begin
            x_out_q <= final_out;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign X_OUT = x_out_q;

endmodule

// File: tb/tb_decodificare_secv.sv
// Scoreboard bench for decodificare_secv: known-answer vector plus encrypt/decrypt round trips.
module tb_decodificare_secv;

  localparam int unsigned NR  = 8;
  localparam int unsigned LAT = 17 * (NR + 1);

  typedef struct packed {
    logic [63:0] p;
    int unsigned due;
  } exp_t;

  logic         clk, rst_n, start, ready, done;
  logic [127:0] K;
  logic [63:0]  Y, X_OUT;

  exp_t        sb[$];
  exp_t        exp_mon;
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [127:0] vec_k [6] = '{
    128'h0000_0000_0000_0000_0000_0000_0000_0000,
    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    128'h0000_0001_0002_0003_FFFF_0001_0000_8000,
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    128'h2BD6_459F_82C5_B300_952C_4910_4881_FF48,
    128'h0001_0002_0003_0004_0005_0006_0007_0008
  };
  logic [63:0] vec_p [6] = '{
    64'h0123_4567_89AB_CDEF,
    64'h0000_0000_0000_0000,
    64'hFFFF_0000_FFFF_0000,
    64'hDEAD_BEEF_CAFE_F00D,
    64'h0001_8000_7FFF_FFFE,
    64'hFFFF_FFFF_FFFF_FFFF
  };

  decodificare_secv #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .K     (K),
    .Y     (Y),
    .ready (ready),
    .done  (done),
    .X_OUT (X_OUT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  // Reference multiply modulo 2^16+1 by plain remainder.
  function automatic logic [15:0] mm(input logic [15:0] a, input logic [15:0] b);
    logic [32:0] x, y, p;
    x = (a == 16'h0) ? 33'h10000 : {17'h0, a};
    y = (b == 16'h0) ? 33'h10000 : {17'h0, b};
    p = (x * y) % 33'd65537;
    return p[15:0];
  endfunction

  // Reference IDEA encryption with NR rounds.
  function automatic logic [63:0] idea_enc(input logic [127:0] k, input logic [63:0] p);
    logic [15:0]  z [64];
    logic [127:0] kk;
    logic [15:0]  x1, x2, x3, x4, t1, t2, t3, t4, e, f, g, h, m;
    kk = k;
    for (int j = 0; j < 64; j++) begin
      z[j] = 16'(kk >> (112 - 16 * (j % 8)));
      if (j % 8 == 7) kk = {kk[102:0], kk[127:103]};
    end
    {x1, x2, x3, x4} = p;
    for (int r = 0; r < NR; r++) begin
      t1 = mm(x1, z[6*r]);
      t2 = x2 + z[6*r+1];
      t3 = x3 + z[6*r+2];
      t4 = mm(x4, z[6*r+3]);
      e  = t1 ^ t3;
      f  = t2 ^ t4;
      g  = mm(e, z[6*r+4]);
      h  = f + g;
      m  = mm(h, z[6*r+5]);
      g  = g + m;
      x1 = t1 ^ m;
      x2 = t3 ^ m;
      x3 = t2 ^ g;
      x4 = t4 ^ g;
    end
    return {mm(x1, z[6*NR]), x3 + z[6*NR+1], x2 + z[6*NR+2], mm(x4, z[6*NR+3])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'h0);
      end else begin
        exp_mon = sb.pop_front();
        check("x_out", X_OUT, exp_mon.p);
        check("latency", 64'(cyc), 64'(exp_mon.due));
        check("ready_at_done", 64'(ready), 64'h1);
      end
    end
  end

  task automatic issue(input logic [127:0] k, input logic [63:0] y, input logic [63:0] p);
    start = 1'b1;
    K     = k;
    Y     = y;
    @(posedge clk);
    #1;
    sb.push_back('{p: p, due: cyc + LAT});
    start = 1'b0;
    K     = {$urandom(), $urandom(), $urandom(), $urandom()};
    Y     = {$urandom(), $urandom()};
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < 2 * LAT + 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 64'h0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [127:0] k, input logic [63:0] p);
    issue(k, idea_enc(k, p), p);
    drain();
  endtask

  initial begin
    logic [127:0] ka, kb, kc;
    logic [63:0]  pa, pb, pc, ya, yb;
    rst_n = 1'b0;
    start = 1'b0;
    K     = '0;
    Y     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'h1);
    check("reset_done", 64'(done), 64'h0);
    check("reset_x_out", X_OUT, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vector.
    issue(128'h0001_0002_0003_0004_0005_0006_0007_0008, 64'h11FB_ED2B_0198_6DE5,
          64'h0000_0001_0002_0003);
    drain();

    for (int i = 0; i < 6; i++) run(vec_k[i], vec_p[i]);
    for (int i = 0; i < 4; i++) begin
      run({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
    end

    // Busy: start held high, inputs changed while running, next block taken on done cycle.
    ka = 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_0001_FFFF;
    kb = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    pa = 64'h1111_2222_3333_4444;
    pb = 64'h8000_0001_0000_FFFF;
    ya = idea_enc(ka, pa);
    yb = idea_enc(kb, pb);
    start = 1'b1;
    K     = ka;
    Y     = ya;
    @(posedge clk);
    #1;
    sb.push_back('{p: pa, due: cyc + LAT});
    K = kb;
    Y = yb;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(posedge clk);
      #1;
      if (i == 5 || i == 100) begin
        check("busy_ready", 64'(ready), 64'h0);
        K = ~kb;
        Y = ~yb;
      end else begin
        K = kb;
        Y = yb;
      end
    end
    @(posedge clk);
    #1;
    sb.push_back('{p: pb, due: cyc + LAT});
    start = 1'b0;
    drain();

    // Reset at cycle 70 of a running block.
    kc = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    pc = 64'h0F0F_F0F0_AAAA_5555;
    start = 1'b1;
    K     = ka;
    Y     = ya;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_ready", 64'(ready), 64'h1);
    check("midrst_done", 64'(done), 64'h0);
    check("midrst_x_out", X_OUT, 64'h0);
    repeat (2 * LAT) @(negedge clk);
    run(kc, pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
